// File: rtl/bitwise_logic_unit.sv
// Bitwise logic unit with accumulator and one-entry registered output; latency 1 cycle.
// in_ready = !out_valid || out_ready: a stalled result holds o/zero stable and blocks new accepts.
module bitwise_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             clr_acc,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] o_q, o_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid_q && out_ready;

  assign o         = o_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;
  assign cnt       = cnt_q;

  // A clear coinciding with an accumulate op feeds zero in place of the stale accumulator.
  always_comb begin
    op_a = i1;
    op_b = i2;
    if (acc) begin
      op_a = clr_acc ? '0 : acc_q;
      op_b = i1;
    end
  end

  always_comb begin
    result = op_a;
    case (op)
      3'b000:  result = op_a & op_b;
      3'b001:  result = op_a | op_b;
      3'b010:  result = op_a ^ op_b;
      3'b011:  result = ~(op_a & op_b);
      3'b100:  result = ~(op_a | op_b);
      3'b101:  result = ~(op_a ^ op_b);
      3'b110:  result = op_a & ~op_b;
      default: result = op_a;
    endcase
  end

  always_comb begin
    o_d         = o_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (accept) begin
      o_d         = result;
      zero_d      = (result == '0);
      out_valid_d = 1'b1;
      cnt_d       = cnt_q + CNT_W'(1);
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end
    if (accept && acc) begin
      acc_d = result;
    end else if (clr_acc) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_q         <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      o_q         <= o_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed and random checks of bitwise_logic_unit against a truth-table reference model.
module tb_bitwise_logic_unit;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, iv, acc_s, clr_s, ordy;
  logic [2:0]    op_s;
  logic [W-1:0]  i1_s, i2_s;
  logic          in_ready, out_valid, zero;
  logic [W-1:0]  o;
  logic [CW-1:0] cnt;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_o;
  logic         m_zero;
  logic         m_vld;
  logic [W-1:0] m_acc;
  int           m_cnt;

  bitwise_logic_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(in_ready), .op(op_s),
    .acc(acc_s), .clr_acc(clr_s), .i1(i1_s), .i2(i2_s), .o(o),
    .out_valid(out_valid), .out_ready(ordy), .zero(zero), .cnt(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each op is a 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_op(input logic [2:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [3:0] tt [8];
    logic [3:0] t;
    logic [W-1:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0100; tt[7] = 4'b1100;
    t = tt[f];
    for (int k = 0; k < W; k++) r[k] = t[{a[k], b[k]}];
    return r;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [2:0] f, input logic a,
                       input logic c, input logic [W-1:0] x1, input logic [W-1:0] x2,
                       input logic ordy_v);
    rst = r; iv = v; op_s = f; acc_s = a; clr_s = c; i1_s = x1; i2_s = x2; ordy = ordy_v;
  endtask

  task automatic cycle();
    logic exp_rdy, acpt, dlv;
    logic [W-1:0] a, b, r;
    #1;
    exp_rdy = !m_vld || ordy;
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    @(posedge clk);
    if (rst) begin
      m_o = '0; m_zero = 1'b1; m_vld = 1'b0; m_acc = '0; m_cnt = 0;
    end else begin
      acpt = iv && exp_rdy;
      dlv  = m_vld && ordy;
      if (acpt) begin
        a = acc_s ? (clr_s ? '0 : m_acc) : i1_s;
        b = acc_s ? i1_s : i2_s;
        r = ref_op(op_s, a, b);
        m_o = r; m_zero = (r == 0); m_vld = 1'b1; m_cnt = (m_cnt + 1) % (1 << CW);
      end else if (dlv) begin
        m_vld = 1'b0;
      end
      if (acpt && acc_s) m_acc = r;
      else if (clr_s)    m_acc = '0;
    end
    #1;
    chk("o", {24'b0, o}, {24'b0, m_o});
    chk("zero", {31'b0, zero}, {31'b0, m_zero});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_vld});
    chk("cnt", {28'b0, cnt}, m_cnt);
  endtask

  initial begin
    m_o = '0; m_zero = 1'b1; m_vld = 1'b0; m_acc = '0; m_cnt = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    #2;
    cycle();
    chk("rst_o", {24'b0, o}, 32'h00);
    chk("rst_zero", {31'b0, zero}, 1);
    chk("rst_vld", {31'b0, out_valid}, 0);
    chk("rst_rdy", {31'b0, in_ready}, 1);
    chk("rst_cnt", {28'b0, cnt}, 0);

    drive(0, 1, 3'b000, 0, 0, 8'hF0, 8'h3C, 1); cycle();
    chk("basic_and_o", {24'b0, o}, 32'h30);
    chk("basic_and_vld", {31'b0, out_valid}, 1);
    chk("basic_and_zero", {31'b0, zero}, 0);
    chk("basic_and_cnt", {28'b0, cnt}, 1);
    drive(0, 1, 3'b010, 0, 0, 8'hAA, 8'hAA, 1); cycle();
    chk("basic_xor_o", {24'b0, o}, 32'h00);
    chk("basic_xor_zero", {31'b0, zero}, 1);

    drive(0, 0, 0, 0, 0, 0, 0, 1); cycle();
    drive(0, 1, 3'b001, 0, 0, 8'h0F, 8'hF0, 0); cycle();
    chk("bp_or_o", {24'b0, o}, 32'hFF);
    drive(0, 1, 3'b000, 0, 0, 8'h0F, 8'hF0, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", {31'b0, in_ready}, 0);
      cycle();
      chk("bp_hold_o", {24'b0, o}, 32'hFF);
      chk("bp_hold_vld", {31'b0, out_valid}, 1);
    end
    ordy = 1'b1; cycle();
    chk("bp_release_o", {24'b0, o}, 32'h00);
    chk("bp_release_vld", {31'b0, out_valid}, 1);

    drive(0, 0, 0, 0, 1, 0, 0, 1); cycle();
    drive(0, 1, 3'b001, 1, 0, 8'h01, 8'hEE, 1); cycle();
    chk("acc_1", {24'b0, o}, 32'h01);
    drive(0, 1, 3'b001, 1, 0, 8'h02, 8'hEE, 1); cycle();
    chk("acc_2", {24'b0, o}, 32'h03);
    drive(0, 1, 3'b001, 1, 0, 8'h04, 8'hEE, 1); cycle();
    chk("acc_3", {24'b0, o}, 32'h07);
    drive(0, 1, 3'b001, 1, 1, 8'h08, 8'hEE, 1); cycle();
    chk("acc_clr", {24'b0, o}, 32'h08);
    drive(0, 1, 3'b111, 1, 0, 8'h55, 8'hEE, 1); cycle();
    chk("acc_hold", {24'b0, o}, 32'h08);

    drive(1, 0, 0, 0, 0, 0, 0, 1); cycle();
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1, 3'($urandom_range(0, 7)), 0, 0, 8'($urandom), 8'($urandom), 1); cycle();
      if (k == 15) chk("cnt_15", {28'b0, cnt}, 15);
    end
    chk("cnt_wrap", {28'b0, cnt}, 0);

    drive(0, 1, 3'b111, 0, 0, 8'h5A, 8'h00, 0); cycle();
    drive(1, 1, 3'b111, 0, 0, 8'h33, 8'h00, 0); cycle();
    chk("rst_pend_vld", {31'b0, out_valid}, 0);
    chk("rst_pend_o", {24'b0, o}, 32'h00);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_pend_rdy", {31'b0, in_ready}, 1);

    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 59) == 0), $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            8'($urandom), 8'($urandom), $urandom_range(0, 2) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the transaction-counter width in bits (CNT_W >= 1).
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: in_valid  input  1  operands and controls valid this cycle.
REQ-007 Port: in_ready  output  1  block can accept an operation this cycle.
REQ-008 Port: op  input  3  operation select.
REQ-009 Port: acc  input  1  accumulate mode for this transaction.
REQ-010 Port: clr_acc  input  1  clear accumulator; sampled every cycle, no handshake.
REQ-011 Port: i1  input  WIDTH  operand 1.
REQ-012 Port: i2  input  WIDTH  operand 2; ignored when acc=1.
REQ-013 Port: o  output  WIDTH  registered result.
REQ-014 Port: out_valid  output  1  o holds an undelivered result.
REQ-015 Port: out_ready  input  1  consumer accepts o this cycle.
REQ-016 Port: zero  output  1  o == 0, registered with o.
REQ-017 Port: cnt  output  CNT_W  count of accepted input transactions.

Function
REQ-018 Accept SHALL occur in a cycle where in_valid && in_ready; deliver SHALL occur where out_valid && out_ready.
REQ-019 in_ready SHALL equal !out_valid || out_ready (combinational; one-entry output register, full throughput).
REQ-020 Operands SHALL be: a=i1, b=i2 when acc=0; a=acc_q, b=i1 when acc=1.
REQ-021 op encoding SHALL be: 000 a&b, 001 a|b, 010 a^b, 011 ~(a&b), 100 ~(a|b), 101 ~(a^b), 110 a&~b, 111 a.
REQ-022 On accept, o SHALL load the result at the next rising edge (latency 1 cycle), zero SHALL load (result==0), and out_valid SHALL be 1.
REQ-023 On deliver without a simultaneous accept, out_valid SHALL go to 0 at the next edge; o and zero SHALL hold their values.
REQ-024 While out_valid=1 and out_ready=0, o, zero and out_valid SHALL hold stable; no new operation SHALL be accepted.
REQ-025 Simultaneous deliver and accept SHALL replace o with the new result, keeping out_valid=1.
REQ-026 Accumulator acc_q (WIDTH bits, internal) SHALL load the result on every accept with acc=1, and SHALL be unchanged on accepts with acc=0.
REQ-027 clr_acc=1 without an acc=1 accept SHALL set acc_q to 0 at the next edge.
REQ-028 clr_acc=1 in the same cycle as an acc=1 accept SHALL use a=0 for that operation, and acc_q SHALL load its result.
REQ-029 cnt SHALL increment by 1 on each accept and wrap from 2^CNT_W-1 to 0.
REQ-030 in_valid=0 cycles SHALL change no state except as given by REQ-023 and REQ-027.

Reset
REQ-031 With reset=1 at a rising edge: o=0, zero=1, out_valid=0, acc_q=0, cnt=0; reset SHALL override accept, deliver and clr_acc in that cycle.
REQ-032 Reset asserted while a result is pending SHALL discard it; in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-033 Reset: assert reset 1 cycle -> o=0x00, zero=1, out_valid=0, in_ready=1, cnt=0.
REQ-034 Basic: op=000, i1=0xF0, i2=0x3C, acc=0, out_ready=1 -> next cycle o=0x30, out_valid=1, zero=0, cnt=1; op=010, i1=i2=0xAA -> o=0x00, zero=1.
REQ-035 Backpressure: out_ready=0, accept op=001 0x0F|0xF0 -> o=0xFF; offer op=000 0x0F&0xF0 -> in_ready=0, o holds 0xFF for 3 cycles; raise out_ready -> 0xFF delivered, then o=0x00.
REQ-036 Accumulate: op=001, acc=1, i1=0x01,0x02,0x04 back-to-back -> o=0x01,0x03,0x07; pulse clr_acc with accept i1=0x08 -> o=0x08.
REQ-037 Wrap and reset: CNT_W=4, 16 accepts -> cnt=0; reset while out_valid=1, out_ready=0 -> out_valid=0, result discarded.
